// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_ctrl_fsm                                                  |
// | Purpose  : Control FSM for a 2-way write-back/write-allocate L1 cache.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cache_ctrl_fsm #(
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_read_i,
    input  logic             cpu_write_i,
    output logic             cpu_resp_o,
    input  logic             mem_resp_i,
    output logic             mem_read_o,
    output logic             mem_write_o,
    input  logic             _hit,
    input  logic             tag0_comp,
    input  logic             tag1_comp,
    input  logic             lru_dataout,
    input  logic             valid0_dataout,
    input  logic             valid1_dataout,
    input  logic             dirty0_dataout,
    input  logic             dirty1_dataout,
    output logic             arr_read,
    output logic             tag0_load,
    output logic             tag1_load,
    output logic             lru_load,
    output logic             dirty0_load,
    output logic             dirty1_load,
    output logic             valid0_load,
    output logic             valid1_load,
    output logic             lru_datain,
    output logic             dirty0_datain,
    output logic             dirty1_datain,
    output logic             valid0_datain,
    output logic             valid1_datain,
    output logic [1:0]       data0_write_en_mux_sel,
    output logic [1:0]       data1_write_en_mux_sel,
    output logic [1:0]       data_out_mux_sel,
    output logic [1:0]       data0_datain_mux_sel,
    output logic [1:0]       data1_datain_mux_sel,
    output logic [1:0]       mem_addr_mux_sel,
    output logic [cnt_w-1:0] hit_cnt_o,
    output logic [cnt_w-1:0] miss_cnt_o,
    output logic [cnt_w-1:0] wb_cnt_o
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_check     = 3'd1;
    localparam logic [2:0] c_st_writeback = 3'd2;
    localparam logic [2:0] c_st_fill      = 3'd3;
    localparam logic [2:0] c_st_refetch   = 3'd4;

    localparam logic [1:0] c_we_zero     = 2'd0;
    localparam logic [1:0] c_we_all_ones = 2'd1;
    localparam logic [1:0] c_we_byte_en  = 2'd2;
    localparam logic [1:0] c_dout_no_hit = 2'd2;
    localparam logic [1:0] c_din_w_data  = 2'd1;
    localparam logic [1:0] c_din_r_data  = 2'd2;
    localparam logic [1:0] c_addr_cpu    = 2'd0;
    localparam logic [1:0] c_addr_tag0   = 2'd1;
    localparam logic [1:0] c_addr_tag1   = 2'd2;

    localparam logic [cnt_w-1:0] c_cnt_max = {cnt_w{1'b1}};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_refill;
    logic             r_victim;
    logic [cnt_w-1:0] r_hit_cnt;
    logic [cnt_w-1:0] r_miss_cnt;
    logic [cnt_w-1:0] r_wb_cnt;

    logic w_hit_way;
    logic w_miss_victim;
    logic w_victim_dirty;
    logic w_hit_inc;
    logic w_miss_inc;
    logic w_wb_inc;
    logic w_fill_done;

    // Way 0 wins if both ways claim a hit; the datapath should never allow it.
    assign w_hit_way      = ~(tag0_comp & valid0_dataout);
    assign w_miss_victim  = !valid0_dataout ? 1'b0 :
                            !valid1_dataout ? 1'b1 : ~lru_dataout;
    assign w_victim_dirty = w_miss_victim ? (valid1_dataout & dirty1_dataout)
                                          : (valid0_dataout & dirty0_dataout);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_refill   <= 1'b0;
            r_victim   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_check && !_hit)
                r_victim <= w_miss_victim;
            if (w_fill_done)
                r_refill <= 1'b1;
            else if (r_state == c_st_check && _hit)
                r_refill <= 1'b0;
            if (w_hit_inc && r_hit_cnt != c_cnt_max)
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_miss_inc && r_miss_cnt != c_cnt_max)
                r_miss_cnt <= r_miss_cnt + 1'b1;
            if (w_wb_inc && r_wb_cnt != c_cnt_max)
                r_wb_cnt <= r_wb_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        w_hit_inc              = 1'b0;
        w_miss_inc             = 1'b0;
        w_wb_inc               = 1'b0;
        w_fill_done            = 1'b0;
        cpu_resp_o             = 1'b0;
        mem_read_o             = 1'b0;
        mem_write_o            = 1'b0;
        arr_read               = 1'b1;
        tag0_load              = 1'b0;
        tag1_load              = 1'b0;
        lru_load               = 1'b0;
        dirty0_load            = 1'b0;
        dirty1_load            = 1'b0;
        valid0_load            = 1'b0;
        valid1_load            = 1'b0;
        lru_datain             = 1'b0;
        dirty0_datain          = 1'b0;
        dirty1_datain          = 1'b0;
        valid0_datain          = 1'b0;
        valid1_datain          = 1'b0;
        data0_write_en_mux_sel = c_we_zero;
        data1_write_en_mux_sel = c_we_zero;
        data_out_mux_sel       = c_dout_no_hit;
        data0_datain_mux_sel   = c_din_r_data;
        data1_datain_mux_sel   = c_din_r_data;
        mem_addr_mux_sel       = c_addr_cpu;

        case (r_state)
            c_st_idle: begin
                if (cpu_read_i || cpu_write_i)
                    w_state_nxt = c_st_check;
            end

            c_st_check: begin
                if (_hit) begin
                    cpu_resp_o       = 1'b1;
                    data_out_mux_sel = {1'b0, w_hit_way};
                    lru_load         = 1'b1;
                    lru_datain       = w_hit_way;
                    if (cpu_write_i) begin
                        if (w_hit_way) begin
                            data1_write_en_mux_sel = c_we_byte_en;
                            data1_datain_mux_sel   = c_din_w_data;
                            dirty1_load            = 1'b1;
                            dirty1_datain          = 1'b1;
                        end else begin
                            data0_write_en_mux_sel = c_we_byte_en;
                            data0_datain_mux_sel   = c_din_w_data;
                            dirty0_load            = 1'b1;
                            dirty0_datain          = 1'b1;
                        end
                    end
                    // The completing CHECK after a refill belongs to the miss.
                    w_hit_inc   = !r_refill;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_miss_inc  = 1'b1;
                    w_state_nxt = w_victim_dirty ? c_st_writeback : c_st_fill;
                end
            end

            c_st_writeback: begin
                mem_write_o      = 1'b1;
                mem_addr_mux_sel = r_victim ? c_addr_tag1 : c_addr_tag0;
                data_out_mux_sel = {1'b0, r_victim};
                if (mem_resp_i) begin
                    w_wb_inc    = 1'b1;
                    w_state_nxt = c_st_fill;
                end
            end

            c_st_fill: begin
                mem_read_o = 1'b1;
                if (mem_resp_i) begin
                    w_fill_done = 1'b1;
                    if (r_victim) begin
                        data1_write_en_mux_sel = c_we_all_ones;
                        tag1_load              = 1'b1;
                        valid1_load            = 1'b1;
                        valid1_datain          = 1'b1;
                        dirty1_load            = 1'b1;
                    end else begin
                        data0_write_en_mux_sel = c_we_all_ones;
                        tag0_load              = 1'b1;
                        valid0_load            = 1'b1;
                        valid0_datain          = 1'b1;
                        dirty0_load            = 1'b1;
                    end
                    w_state_nxt = c_st_refetch;
                end
            end

            c_st_refetch: begin
                w_state_nxt = c_st_check;
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
    assign wb_cnt_o   = r_wb_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_ctrl_fsm                                               |
// | Purpose  : Scoreboard bench for cache_ctrl_fsm with a one-set array model.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cache_ctrl_fsm;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cpu_read_i, cpu_write_i, cpu_resp_o, mem_resp_i, mem_read_o, mem_write_o;
    logic w_hit, tag0_comp, tag1_comp, lru_dataout;
    logic valid0_dataout, valid1_dataout, dirty0_dataout, dirty1_dataout;
    logic arr_read, tag0_load, tag1_load, lru_load, dirty0_load, dirty1_load;
    logic valid0_load, valid1_load, lru_datain, dirty0_datain, dirty1_datain;
    logic valid0_datain, valid1_datain;
    logic [1:0] data0_write_en_mux_sel, data1_write_en_mux_sel, data_out_mux_sel;
    logic [1:0] data0_datain_mux_sel, data1_datain_mux_sel, mem_addr_mux_sel;
    logic [CW-1:0] hit_cnt_o, miss_cnt_o, wb_cnt_o;

    cache_ctrl_fsm #(.cnt_w(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i), .cpu_resp_o(cpu_resp_o),
        .mem_resp_i(mem_resp_i), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        ._hit(w_hit), .tag0_comp(tag0_comp), .tag1_comp(tag1_comp), .lru_dataout(lru_dataout),
        .valid0_dataout(valid0_dataout), .valid1_dataout(valid1_dataout),
        .dirty0_dataout(dirty0_dataout), .dirty1_dataout(dirty1_dataout),
        .arr_read(arr_read), .tag0_load(tag0_load), .tag1_load(tag1_load),
        .lru_load(lru_load), .dirty0_load(dirty0_load), .dirty1_load(dirty1_load),
        .valid0_load(valid0_load), .valid1_load(valid1_load), .lru_datain(lru_datain),
        .dirty0_datain(dirty0_datain), .dirty1_datain(dirty1_datain),
        .valid0_datain(valid0_datain), .valid1_datain(valid1_datain),
        .data0_write_en_mux_sel(data0_write_en_mux_sel),
        .data1_write_en_mux_sel(data1_write_en_mux_sel),
        .data_out_mux_sel(data_out_mux_sel),
        .data0_datain_mux_sel(data0_datain_mux_sel),
        .data1_datain_mux_sel(data1_datain_mux_sel),
        .mem_addr_mux_sel(mem_addr_mux_sel),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
    );

    // Datapath arrays for the single set exercised; written only by DUT loads.
    bit dp_valid [2];
    bit dp_dirty [2];
    int dp_tag   [2];
    bit dp_lru;
    int cur_tag;

    assign tag0_comp      = (dp_tag[0] == cur_tag);
    assign tag1_comp      = (dp_tag[1] == cur_tag);
    assign valid0_dataout = dp_valid[0];
    assign valid1_dataout = dp_valid[1];
    assign dirty0_dataout = dp_dirty[0];
    assign dirty1_dataout = dp_dirty[1];
    assign lru_dataout    = dp_lru;
    assign w_hit          = (tag0_comp & valid0_dataout) | (tag1_comp & valid1_dataout);

    // Reference cache state and expected counters.
    bit ref_valid [2];
    bit ref_dirty [2];
    int ref_tag   [2];
    bit ref_lru;
    int e_hit, e_miss, e_wb;

    typedef struct {
        bit miss;
        bit wb;
        int way;
        int lat;
        bit wr;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input bit wr, input int tag);
        exp_t e;
        bit h0, h1;
        int w;
        h0 = ref_valid[0] && ref_tag[0] == tag;
        h1 = ref_valid[1] && ref_tag[1] == tag;
        if (h0 || h1) begin
            w = h0 ? 0 : 1;
            e.miss = 0;
            e.wb = 0;
            if (e_hit < CMAX) e_hit++;
        end else begin
            w = !ref_valid[0] ? 0 : !ref_valid[1] ? 1 : (ref_lru ? 0 : 1);
            e.miss = 1;
            e.wb = ref_valid[w] && ref_dirty[w];
            if (e_miss < CMAX) e_miss++;
            if (e.wb && e_wb < CMAX) e_wb++;
            ref_valid[w] = 1;
            ref_tag[w] = tag;
            ref_dirty[w] = 0;
        end
        ref_lru = (w == 1);
        if (wr) ref_dirty[w] = 1;
        e.way = w;
        e.wr = wr;
        // Miss: CHECK, 5 fill cycles, REFETCH, CHECK; writeback adds 3 cycles.
        e.lat = 1 + (e.miss ? 7 : 0) + (e.wb ? 3 : 0);
        sb.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at the next negedge.
    task automatic run_req(input bit wr, input bit both, input int tag);
        exp_t e;
        int cyc, rd_wait, wr_wait, v;
        bit done, saw_rd, saw_wr;
        bit p_t0, p_t1, p_v0, p_v1, p_d0, p_d1, p_l, p_vd0, p_vd1, p_dd0, p_dd1, p_ld;
        push_expect(wr, tag);
        cur_tag = tag;
        cpu_write_i = wr;
        cpu_read_i = !wr || both;
        cyc = 0; rd_wait = 0; wr_wait = 0;
        done = 0; saw_rd = 0; saw_wr = 0;
        v = sb[0].way;
        while (!done && cyc < 60) begin
            mem_resp_i = 1'b0;
            if (mem_read_o) begin
                if (rd_wait == 4) mem_resp_i = 1'b1;
                rd_wait++;
            end
            if (mem_write_o) begin
                if (wr_wait == 2) mem_resp_i = 1'b1;
                wr_wait++;
            end
            #1;
            if (mem_read_o && mem_write_o) chk_eq("rd_wr_exclusive", 1, 0);
            if (mem_write_o) begin
                saw_wr = 1;
                chk_eq("wb_addr_sel", mem_addr_mux_sel, v + 1);
                chk_eq("wb_dout_sel", data_out_mux_sel, v);
            end
            if (mem_read_o) begin
                saw_rd = 1;
                chk_eq("fill_addr_sel", mem_addr_mux_sel, 0);
                if (mem_resp_i) begin
                    chk_eq("fill_we_sel", v ? data1_write_en_mux_sel : data0_write_en_mux_sel, 1);
                    chk_eq("fill_tag_load", {tag1_load, tag0_load}, v ? 2 : 1);
                    chk_eq("fill_valid", {valid1_load, valid0_load, valid1_datain, valid0_datain},
                           v ? 4'b1010 : 4'b0101);
                    chk_eq("fill_dirty", {dirty1_load, dirty0_load, dirty1_datain, dirty0_datain},
                           v ? 4'b1000 : 4'b0100);
                end
            end
            if (cpu_resp_o) begin
                e = sb.pop_front();
                done = 1;
                chk_eq("latency", cyc, e.lat);
                chk_eq("saw_fill", saw_rd, e.miss);
                chk_eq("saw_wb", saw_wr, e.wb);
                chk_eq("hit_dout_sel", data_out_mux_sel, e.way);
                chk_eq("lru_update", {lru_load, lru_datain}, {1'b1, e.way == 1});
                chk_eq("we_sels", {data1_write_en_mux_sel, data0_write_en_mux_sel},
                       !e.wr ? 4'b0000 : (e.way ? 4'b1000 : 4'b0010));
                chk_eq("din_sels", {data1_datain_mux_sel, data0_datain_mux_sel},
                       !e.wr ? 4'b1010 : (e.way ? 4'b0110 : 4'b1001));
                chk_eq("hit_dirty", {dirty1_load, dirty0_load, dirty1_datain, dirty0_datain},
                       !e.wr ? 4'b0000 : (e.way ? 4'b1010 : 4'b0101));
            end
            p_t0 = tag0_load; p_t1 = tag1_load; p_v0 = valid0_load; p_v1 = valid1_load;
            p_d0 = dirty0_load; p_d1 = dirty1_load; p_l = lru_load;
            p_vd0 = valid0_datain; p_vd1 = valid1_datain;
            p_dd0 = dirty0_datain; p_dd1 = dirty1_datain; p_ld = lru_datain;
            @(posedge clk);
            #1;
            if (p_t0) dp_tag[0] = cur_tag;
            if (p_t1) dp_tag[1] = cur_tag;
            if (p_v0) dp_valid[0] = p_vd0;
            if (p_v1) dp_valid[1] = p_vd1;
            if (p_d0) dp_dirty[0] = p_dd0;
            if (p_d1) dp_dirty[1] = p_dd1;
            if (p_l) dp_lru = p_ld;
            if (!done) begin
                cyc++;
                @(negedge clk);
            end
        end
        cpu_read_i = 1'b0;
        cpu_write_i = 1'b0;
        mem_resp_i = 1'b0;
        if (!done) begin
            chk_eq("resp_timeout", 0, 1);
            sb.delete();
        end
        chk_eq("hit_cnt", hit_cnt_o, e_hit);
        chk_eq("miss_cnt", miss_cnt_o, e_miss);
        chk_eq("wb_cnt", wb_cnt_o, e_wb);
        chk_eq("arr_state", {dp_valid[1], dp_valid[0], dp_dirty[1], dp_dirty[0]},
               {ref_valid[1], ref_valid[0], ref_dirty[1], ref_dirty[0]});
        @(negedge clk);
    endtask

    localparam int TAG_A = 'h0;
    localparam int TAG_B = 'h1;
    localparam int TAG_C = 'h2;

    initial begin
        int k;
        rst = 1'b1;
        cpu_read_i = 1'b0;
        cpu_write_i = 1'b0;
        mem_resp_i = 1'b0;
        cur_tag = TAG_A;
        for (int i = 0; i < 2; i++) begin
            dp_valid[i] = 0; dp_dirty[i] = 0; dp_tag[i] = -1;
            ref_valid[i] = 0; ref_dirty[i] = 0; ref_tag[i] = -1;
        end
        dp_lru = 0; ref_lru = 0;
        e_hit = 0; e_miss = 0; e_wb = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_outputs", {cpu_resp_o, mem_read_o, mem_write_o, arr_read}, 4'b0001);
        chk_eq("rst_sels", {data_out_mux_sel, mem_addr_mux_sel}, 4'b1000);
        chk_eq("rst_counters", {hit_cnt_o, miss_cnt_o, wb_cnt_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(0, 0, TAG_A);   // cold miss, fills way0
        run_req(0, 0, TAG_A);   // hit way0
        run_req(1, 0, TAG_A);   // store hit, way0 dirty

        // A stray completion pulse while idle must be ignored.
        mem_resp_i = 1'b1;
        @(negedge clk);
        mem_resp_i = 1'b0;
        chk_eq("stray_resp", {mem_read_o, mem_write_o, cpu_resp_o}, 0);

        run_req(0, 0, TAG_B);   // miss into invalid way1, LRU -> way0
        run_req(0, 0, TAG_C);   // dirty victim way0: writeback then fill
        run_req(1, 1, TAG_B);   // read+write together acts as a store
        for (k = 0; k < 16; k++)
            run_req(0, 0, (k % 2) ? TAG_B : TAG_C);

        // Abort a fill with reset.
        cur_tag = TAG_A;
        cpu_read_i = 1'b1;
        k = 0;
        while (!mem_read_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk_eq("fill_reached", mem_read_o, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cpu_read_i = 1'b0;
        chk_eq("rst_abort_mem", {mem_read_o, mem_write_o, cpu_resp_o}, 0);
        chk_eq("rst_abort_cnt", {hit_cnt_o, miss_cnt_o, wb_cnt_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        e_hit = 0; e_miss = 0; e_wb = 0;
        @(negedge clk);
        run_req(0, 0, TAG_A);   // fresh miss after the aborted one
        run_req(1, 0, TAG_C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
